audio_sample_out: RTL and testbench
===================================

Name: audio_sample_out

Overview:
- Output end of the per-sample schedule driven by the sample-cycle counter (0..2271 at 100 MHz, 44.0 kHz).
- Synthesis pipeline pushes finished signed samples through a valid/ready interface into a small FIFO.
- Once per sample period, at a fixed counter phase, one sample is popped and held.
- A first-order sigma-delta modulator turns the held sample into a 1-bit PWM stream for the board audio jack.

Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- TICK_PHASE, 0: sample_cycle_count value that triggers a pop; must be < 2272.
- SAMPLE_W, 16: sample width in bits; take it from the package, do not override.

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous, active-low reset
- sample_cycle_count  in  12  free-running per-sample cycle counter
- s_data  in  SAMPLE_W  signed two's-complement sample
- s_valid  in  1  s_data is valid
- s_ready  out  1  FIFO can accept a sample
- underrun_clear  in  1  synchronous clear of underrun_count
- pwm_out  out  1  1-bit sigma-delta audio output
- cur_sample  out  SAMPLE_W  sample currently being modulated
- fifo_level  out  $clog2(DEPTH+1)  occupied FIFO entries
- underrun_count  out  16  saturating count of ticks that found the FIFO empty

Behaviour:
- Reset (async assert, sync release) sets:
  - s_ready=0 during reset, then 1 from the first clock after release.
  - pwm_out=0, cur_sample=0 (midscale), fifo_level=0, underrun_count=0.
  - Modulator accumulator=0; FIFO pointers=0.
- Push:
  - Occurs when s_valid && s_ready at a clk edge.
  - s_ready is registered: s_ready = (level < DEPTH) as of the previous cycle's post-edge state; it has no combinational path from a same-cycle pop.
  - Data must stay stable while s_valid && !s_ready; the FIFO never drops an accepted sample.
- Tick:
  - tick = (sample_cycle_count == TICK_PHASE), evaluated combinationally and acted on at that edge.
  - Tick with level>0: pop the head into cur_sample at that edge.
  - Tick with level==0: cur_sample holds its previous value; underrun_count increments, saturating at 16'hFFFF.
- Simultaneous push and pop: level unchanged, both take effect.
  - Push into an empty FIFO on a tick cycle is not visible to that pop, so it counts as an underrun.
  - The pushed sample is popped at the next tick.
- underrun_clear:
  - Zeroes the counter at the next edge.
  - If asserted on an underrun tick, clear wins; count is 0.
- Modulator, every cycle:
  - u = {~cur_sample[MSB], cur_sample[MSB-1:0]} (offset binary).
  - {c, acc} <= acc + u, with a (SAMPLE_W+1)-bit sum.
  - pwm_out <= c.
  - Long-run duty = u/2^SAMPLE_W. Max positive input gives duty 65535/65536; min negative gives constant 0.
- Latency:
  - Tick at edge T loads cur_sample.
  - The first accumulate using the new sample is at edge T+1; pwm_out reflects it after edge T+1.
- Ordering: strict FIFO; wrap-around of read/write pointers modulo DEPTH. fifo_level counts 0..DEPTH inclusive.

Decomposition:
- audio_pkg holds:
  - SAMPLE_W=16
  - typedef logic signed [SAMPLE_W-1:0] sample_t
  - SAMPLE_CYCLE_LENGTH=2272
  - SAMPLE_CNT_W=12
- One sub-module, sigma_delta_dac (inputs clk, rst_n, sample_t din; output pwm), instantiated once.
- The FIFO stays inline.

Test Plan:
- Reset then idle, count cycling 0..2271, no pushes:
  - cur_sample=0 throughout.
  - pwm_out alternates 0,1 each cycle, starting 0,1 after the first edge.
  - underrun_count increments once per 2272 cycles.
- Push 5 samples back-to-back with DEPTH=4 and no tick:
  - s_ready drops after the 4th accept; fifo_level=4.
  - 5th sample is held off until the next tick frees space.
  - Pops arrive in order: 100, 200, 300, 400, 500.
- Push 16'sh7FFF and let it tick in: pwm_out high in 65535 of every 65536 cycles.
- Push 16'sh8000: pwm_out constantly 0 after the load.
- Push into an empty FIFO on the tick cycle (count==TICK_PHASE): underrun_count +1, cur_sample unchanged, sample popped at the next tick.
- underrun_count forced to 16'hFFFF, then further empty ticks: stays 16'hFFFF.
  - underrun_clear on an underrun tick → 0.
  - Assert rst_n low mid-stream: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio output path.
// Sample format and per-sample cycle schedule.
package audio_pkg;
  localparam int SAMPLE_W = 16;
  localparam int SAMPLE_CYCLE_LENGTH = 2272;
  localparam int SAMPLE_CNT_W = 12;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/audio_sample_out_dac.sv
// First-order sigma-delta modulator producing a 1-bit PWM stream.
// The carry of the offset-binary accumulation is the output bit.
module sigma_delta_dac
  import audio_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  sample_t din,
  output logic    pwm
);

  logic [SAMPLE_W-1:0] acc;
  logic [SAMPLE_W-1:0] u;
  logic [SAMPLE_W:0]   sum;

  always_comb begin
    u   = {~din[SAMPLE_W-1], din[SAMPLE_W-2:0]};
    sum = {1'b0, acc} + {1'b0, u};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      pwm <= 1'b0;
    end else begin
      acc <= sum[SAMPLE_W-1:0];
      pwm <= sum[SAMPLE_W];
    end
  end

endmodule

// File: rtl/audio_sample_out.sv
// Sample FIFO, once-per-period pop into the held sample,
// underrun counter and sigma-delta output stage.
module audio_sample_out
  import audio_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int TICK_PHASE = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [SAMPLE_CNT_W-1:0]      sample_cycle_count,
  input  sample_t                      s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic                         underrun_clear,
  output logic                         pwm_out,
  output sample_t                      cur_sample,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic [15:0]                  underrun_count
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  localparam logic [LW-1:0] ONE = LW'(1);
  localparam logic [PW-1:0] PONE = PW'(1);
  localparam logic [SAMPLE_CNT_W-1:0] PHASE = SAMPLE_CNT_W'(TICK_PHASE);

  sample_t       mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [LW-1:0] level_next;
  logic          tick;
  logic          empty;
  logic          push;
  logic          pop;

  always_comb begin
    tick  = sample_cycle_count == PHASE;
    empty = fifo_level == '0;
    push  = s_valid && s_ready;
    pop   = tick && !empty;
    level_next = fifo_level;
    unique case (1'b1)
      push && !pop: level_next = fifo_level + ONE;
      pop && !push: level_next = fifo_level - ONE;
      default:      level_next = fifo_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  // Ready looks only at registered level, never at a same-cycle pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
      s_ready    <= 1'b0;
      cur_sample <= '0;
    end else begin
      fifo_level <= level_next;
      s_ready    <= level_next != FULL;
      if (push) wr_ptr <= wr_ptr + PONE;
      if (pop) begin
        rd_ptr     <= rd_ptr + PONE;
        cur_sample <= mem[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_count <= '0;
    end else if (underrun_clear) begin
      underrun_count <= '0;
    end else if (tick && empty && underrun_count != 16'hFFFF) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end

  sigma_delta_dac u_dac (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (cur_sample),
    .pwm   (pwm_out)
  );

endmodule

// File: tb/tb_audio_sample_out.sv
// Directed bench for audio_sample_out: FIFO vectors, tick
// corner cases, modulator duty extremes, underrun saturation.
module tb_audio_sample_out;
  import audio_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] cnt;
  sample_t     s_data;
  logic        s_valid;
  logic        s_ready;
  logic        clr;
  logic        pwm_out;
  sample_t     cur_sample;
  logic [2:0]  fifo_level;
  logic [15:0] underrun_count;

  int errs = 0;
  int checks = 0;

  audio_sample_out #(.DEPTH(4), .TICK_PHASE(0)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .sample_cycle_count (cnt),
    .s_data             (s_data),
    .s_valid            (s_valid),
    .s_ready            (s_ready),
    .underrun_clear     (clr),
    .pwm_out            (pwm_out),
    .cur_sample         (cur_sample),
    .fifo_level         (fifo_level),
    .underrun_count     (underrun_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [15:0] data;
    logic [11:0] cnt;
    logic [2:0]  lvl;
    logic        rdy;
    logic [15:0] cur;
    logic [15:0] und;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_u;
    int alt_err;
    int cur_err;
    int u_err;
    int zeros;
    int ones;
    logic prev;
    logic was0;

    tbl[0]  = '{1'b1, 16'd100, 12'd5, 3'd1, 1'b1, 16'd0,   16'd2};
    tbl[1]  = '{1'b1, 16'd200, 12'd5, 3'd2, 1'b1, 16'd0,   16'd2};
    tbl[2]  = '{1'b1, 16'd300, 12'd5, 3'd3, 1'b1, 16'd0,   16'd2};
    tbl[3]  = '{1'b1, 16'd400, 12'd5, 3'd4, 1'b0, 16'd0,   16'd2};
    tbl[4]  = '{1'b1, 16'd500, 12'd5, 3'd4, 1'b0, 16'd0,   16'd2};
    tbl[5]  = '{1'b1, 16'd500, 12'd0, 3'd3, 1'b1, 16'd100, 16'd2};
    tbl[6]  = '{1'b1, 16'd500, 12'd5, 3'd4, 1'b0, 16'd100, 16'd2};
    tbl[7]  = '{1'b0, 16'd0,   12'd0, 3'd3, 1'b1, 16'd200, 16'd2};
    tbl[8]  = '{1'b0, 16'd0,   12'd0, 3'd2, 1'b1, 16'd300, 16'd2};
    tbl[9]  = '{1'b0, 16'd0,   12'd0, 3'd1, 1'b1, 16'd400, 16'd2};
    tbl[10] = '{1'b0, 16'd0,   12'd0, 3'd0, 1'b1, 16'd500, 16'd2};
    tbl[11] = '{1'b0, 16'd0,   12'd0, 3'd0, 1'b1, 16'd500, 16'd3};

    rst_n = 1'b0;
    cnt = 12'd5;
    s_data = '0;
    s_valid = 1'b0;
    clr = 1'b0;
    #22;
    chk("rst_ready", 32'(s_ready), 0);
    chk("rst_pwm", 32'(pwm_out), 0);
    chk("rst_cur", {16'b0, cur_sample}, 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_under", 32'(underrun_count), 0);
    rst_n = 1'b1;
    step();
    chk("first_ready", 32'(s_ready), 1);
    chk("first_pwm", 32'(pwm_out), 0);
    step();
    chk("second_pwm", 32'(pwm_out), 1);
    prev = pwm_out;

    // Idle: free-running count, two full periods, no pushes.
    cnt = 12'd1;
    exp_u = 0;
    alt_err = 0;
    cur_err = 0;
    u_err = 0;
    for (int i = 0; i < 2 * SAMPLE_CYCLE_LENGTH; i++) begin
      was0 = cnt == 12'd0;
      step();
      if (was0) exp_u++;
      if (pwm_out === prev) alt_err++;
      if (cur_sample !== '0) cur_err++;
      if (underrun_count !== 16'(exp_u)) u_err++;
      prev = pwm_out;
      cnt = (cnt == 12'd2271) ? 12'd0 : cnt + 12'd1;
    end
    chk("idle_pwm_alt_errs", 32'(alt_err), 0);
    chk("idle_cur_errs", 32'(cur_err), 0);
    chk("idle_under_errs", 32'(u_err), 0);
    chk("idle_under", 32'(underrun_count), 2);

    for (int i = 0; i < 12; i++) begin
      s_valid = tbl[i].valid;
      s_data = tbl[i].data;
      cnt = tbl[i].cnt;
      step();
      chk($sformatf("v%0d_level", i), 32'(fifo_level), 32'(tbl[i].lvl));
      chk($sformatf("v%0d_ready", i), 32'(s_ready), 32'(tbl[i].rdy));
      chk($sformatf("v%0d_cur", i), {16'b0, cur_sample}, {16'b0, tbl[i].cur});
      chk($sformatf("v%0d_under", i), 32'(underrun_count), {16'b0, tbl[i].und});
    end

    // Push on a tick into an empty FIFO: underrun, popped next tick.
    s_valid = 1'b1;
    s_data = 16'hFB2E;
    cnt = 12'd0;
    step();
    chk("tp_level", 32'(fifo_level), 1);
    chk("tp_under", 32'(underrun_count), 4);
    chk("tp_cur", {16'b0, cur_sample}, 32'h01F4);
    s_valid = 1'b0;
    cnt = 12'd5;
    step();
    cnt = 12'd0;
    step();
    chk("tp_pop_cur", {16'b0, cur_sample}, 32'hFB2E);
    chk("tp_pop_level", 32'(fifo_level), 0);
    chk("tp_pop_under", 32'(underrun_count), 4);

    // Max positive sample: at most one low cycle in 2000.
    s_valid = 1'b1;
    s_data = 16'h7FFF;
    cnt = 12'd5;
    step();
    s_valid = 1'b0;
    cnt = 12'd0;
    step();
    chk("maxpos_cur", {16'b0, cur_sample}, 32'h7FFF);
    cnt = 12'd5;
    zeros = 0;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (pwm_out !== 1'b1) zeros++;
    end
    chk("maxpos_duty_ok", 32'(zeros <= 1), 1);

    // Min negative sample: output stays low from T+1.
    s_valid = 1'b1;
    s_data = 16'h8000;
    step();
    s_valid = 1'b0;
    cnt = 12'd0;
    step();
    chk("minneg_cur", {16'b0, cur_sample}, 32'h8000);
    cnt = 12'd5;
    ones = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (pwm_out !== 1'b0) ones++;
    end
    chk("minneg_ones", 32'(ones), 0);

    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clear_under", 32'(underrun_count), 0);

    // Tick every cycle with empty FIFO to reach saturation.
    cnt = 12'd0;
    for (int i = 0; i < 65535; i++) step();
    chk("sat_reach", 32'(underrun_count), 32'hFFFF);
    step();
    step();
    chk("sat_hold", 32'(underrun_count), 32'hFFFF);
    chk("sat_cur", {16'b0, cur_sample}, 32'h8000);
    clr = 1'b1;
    step();
    chk("clr_on_tick", 32'(underrun_count), 0);
    clr = 1'b0;
    step();
    chk("after_clr_tick", 32'(underrun_count), 1);

    // Asynchronous reset in the middle of a cycle.
    cnt = 12'd5;
    s_valid = 1'b1;
    s_data = 16'd7;
    step();
    s_valid = 1'b0;
    chk("pre_rst_level", 32'(fifo_level), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_level", 32'(fifo_level), 0);
    chk("arst_cur", {16'b0, cur_sample}, 0);
    chk("arst_ready", 32'(s_ready), 0);
    chk("arst_under", 32'(underrun_count), 0);
    chk("arst_pwm", 32'(pwm_out), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
